// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt trap and MRET sequencer: drains the pipe, writes the
// trap CSRs, and redirects fetch to the trap vector or back to mepc.
module irq_trap_ctrl #(
  parameter bit VEC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] next_pc,
  input  logic        pipe_empty,
  input  logic        mret_req,
  input  logic        redirect_ready,
  output logic        fetch_hold,
  output logic        trap_wr,
  output logic [31:0] mepc_out,
  output logic [31:0] mcause_out,
  output logic        mret_restore,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_SAVE       = 3'd2,
    ST_REDIR_TRAP = 3'd3,
    ST_MRET       = 3'd4,
    ST_REDIR_RET  = 3'd5
  } state_e;

  // Fixed priority: external > software > timer.
  function automatic logic [3:0] pick_cause(input logic [31:0] pend);
    logic [3:0] code;
    if (pend[11]) begin
      code = 4'd11;
    end else if (pend[3]) begin
      code = 4'd3;
    end else begin
      code = 4'd7;
    end
    return code;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] pend_s;
  logic        eligible_s;
  logic        abort_s;
  logic        vec_mode_s;
  logic [31:0] trap_tgt_s;

  assign pend_s     = mip & mie & IRQ_MASK;
  assign eligible_s = mstatus_mie & (|pend_s);
  assign abort_s    = ~pend_s[{1'b0, cause_q}] | ~mstatus_mie;
  assign vec_mode_s = (VEC_EN == 1'b1) && (mtvec[1:0] == 2'b01);
  // Vector offset is added modulo 2^32; any carry out is dropped.
  assign trap_tgt_s = {mtvec[31:2], 2'b00}
                    + (vec_mode_s ? {26'd0, cause_q, 2'b00} : 32'd0);

  // State and captured-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cause_q <= 4'd0;
      epc_q   <= 32'd0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic; the redirect target is latched on entry so it holds
  // steady while fetch back-pressures.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (mret_req) begin
          state_d = ST_MRET;
        end else if (eligible_s) begin
          cause_d = pick_cause(pend_s);
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (pipe_empty) begin
          epc_d   = next_pc;
          state_d = ST_SAVE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_SAVE: begin
        tgt_d   = trap_tgt_s;
        state_d = ST_REDIR_TRAP;
      end
      ST_MRET: begin
        tgt_d   = {mepc[31:2], 2'b00};
        state_d = ST_REDIR_RET;
      end
      ST_REDIR_TRAP, ST_REDIR_RET: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    fetch_hold     = 1'b0;
    trap_wr        = 1'b0;
    mepc_out       = 32'd0;
    mcause_out     = 32'd0;
    mret_restore   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    busy           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_DRAIN: begin
        fetch_hold = 1'b1;
        busy       = 1'b1;
      end
      ST_SAVE: begin
        fetch_hold = 1'b1;
        busy       = 1'b1;
        trap_wr    = 1'b1;
        mepc_out   = epc_q;
        mcause_out = {1'b1, 26'd0, 1'b0, cause_q};
      end
      ST_MRET: begin
        fetch_hold   = 1'b1;
        busy         = 1'b1;
        mret_restore = 1'b1;
      end
      ST_REDIR_TRAP, ST_REDIR_RET: begin
        fetch_hold     = 1'b1;
        busy           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios plus randomized
// trials checked against a cycle-count/arithmetic reference model.
module tb_irq_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] mip, mie, mtvec, mepc, next_pc;
  logic        mstatus_mie, pipe_empty, mret_req, redirect_ready;
  logic        fetch_hold, trap_wr, mret_restore, redirect_valid, busy;
  logic [31:0] mepc_out, mcause_out, redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Observation record filled by observe().
  int          o_trap, o_mret, o_redir;
  int          o_trap_cyc, o_mret_cyc, o_redir_cyc;
  logic [31:0] o_mcause, o_mepc, o_rpc;

  irq_trap_ctrl #(.VEC_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mip(mip), .mie(mie), .mstatus_mie(mstatus_mie),
    .mtvec(mtvec), .mepc(mepc), .next_pc(next_pc), .pipe_empty(pipe_empty),
    .mret_req(mret_req), .redirect_ready(redirect_ready),
    .fetch_hold(fetch_hold), .trap_wr(trap_wr), .mepc_out(mepc_out),
    .mcause_out(mcause_out), .mret_restore(mret_restore),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: trap cause from priority rules.
  function automatic int model_code(input logic [31:0] p);
    if ((p & 32'h800) != 32'd0) return 11;
    if ((p & 32'h008) != 32'd0) return 3;
    return 7;
  endfunction

  // Reference model: trap target address, 32-bit wrap.
  function automatic logic [31:0] model_vec(input logic [31:0] tv, input int code);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
    if ((tv & 32'd3) == 32'd1) return base + 32'(code * 4);
    return base;
  endfunction

  // Step ncyc cycles sampling on the falling edge; mret_req is a one-cycle
  // pulse and pending interrupts are retired once a redirect is accepted.
  task automatic observe(input int ncyc);
    o_trap = 0; o_mret = 0; o_redir = 0;
    o_trap_cyc = -1; o_mret_cyc = -1; o_redir_cyc = -1;
    o_mcause = 32'd0; o_mepc = 32'd0; o_rpc = 32'd0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      mret_req = 1'b0;
      if (trap_wr) begin
        o_trap++; o_trap_cyc = c; o_mcause = mcause_out; o_mepc = mepc_out;
      end
      if (mret_restore) begin
        o_mret++; o_mret_cyc = c;
      end
      if (redirect_valid && redirect_ready) begin
        o_redir++; o_redir_cyc = c; o_rpc = redirect_pc; mip = 32'd0;
      end
    end
  endtask

  task automatic idle_inputs();
    mip = 32'd0; mie = 32'd0; mstatus_mie = 1'b1; mtvec = 32'h100;
    mepc = 32'd0; next_pc = 32'd0; pipe_empty = 1'b1; mret_req = 1'b0;
    redirect_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({fetch_hold, trap_wr, mret_restore, redirect_valid, busy} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b want 00000",
        {fetch_hold, trap_wr, mret_restore, redirect_valid, busy});
    end
    n_checks++;
    if ({mepc_out, mcause_out, redirect_pc} !== 96'd0) begin
      n_errors++; $display("FAIL reset_data: got %h %h %h want 0", mepc_out, mcause_out, redirect_pc);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_trap(input string nm, input logic [31:0] pend, input logic [31:0] tv,
                           input logic [31:0] exp_cause, input logic [31:0] exp_pc);
    idle_inputs();
    mip = pend; mie = pend; mtvec = tv; next_pc = 32'h2000;
    observe(6);
    n_checks++;
    if (o_trap !== 1 || o_trap_cyc !== 2) begin
      n_errors++; $display("FAIL %s_trap_wr: got count %0d cycle %0d want 1 at 2", nm, o_trap, o_trap_cyc);
    end
    n_checks++;
    if (o_mcause !== exp_cause) begin
      n_errors++; $display("FAIL %s_mcause: got %h want %h", nm, o_mcause, exp_cause);
    end
    n_checks++;
    if (o_mepc !== 32'h2000) begin
      n_errors++; $display("FAIL %s_mepc: got %h want 00002000", nm, o_mepc);
    end
    n_checks++;
    if (o_rpc !== exp_pc || o_redir_cyc !== 3) begin
      n_errors++; $display("FAIL %s_redirect: got %h at %0d want %h at 3", nm, o_rpc, o_redir_cyc, exp_pc);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL %s_idle_after: busy got %b want 0", nm, busy);
    end
  endtask

  task automatic test_abort();
    idle_inputs();
    mip = 32'h880; mie = 32'h880; pipe_empty = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fetch_hold !== 1'b1) begin
      n_errors++; $display("FAIL abort_drain_hold: got %b want 1", fetch_hold);
    end
    mie = 32'h080;
    @(negedge clk);
    n_checks++;
    if (fetch_hold !== 1'b0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_to_idle: hold %b busy %b want 0 0", fetch_hold, busy);
    end
    mip = 32'd0;
    observe(4);
    n_checks++;
    if (o_trap !== 0) begin
      n_errors++; $display("FAIL abort_no_trap: got %0d trap_wr want 0", o_trap);
    end
  endtask

  task automatic test_abort_vs_empty();
    idle_inputs();
    mip = 32'h008; mie = 32'h008; pipe_empty = 1'b0;
    @(negedge clk);
    pipe_empty = 1'b1; mstatus_mie = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || trap_wr !== 1'b0) begin
      n_errors++; $display("FAIL abort_wins: busy %b trap_wr %b want 0 0", busy, trap_wr);
    end
    observe(4);
    n_checks++;
    if (o_trap !== 0) begin
      n_errors++; $display("FAIL abort_wins_no_trap: got %0d want 0", o_trap);
    end
    mip = 32'd0;
  endtask

  task automatic test_mret_priority();
    idle_inputs();
    mip = 32'h880; mie = 32'h880; mepc = 32'h3006; mret_req = 1'b1;
    observe(5);
    n_checks++;
    if (o_mret !== 1 || o_mret_cyc !== 1) begin
      n_errors++; $display("FAIL mret_pulse: got %0d at %0d want 1 at 1", o_mret, o_mret_cyc);
    end
    n_checks++;
    if (o_rpc !== 32'h3004 || o_redir_cyc !== 2) begin
      n_errors++; $display("FAIL mret_redirect: got %h at %0d want 00003004 at 2", o_rpc, o_redir_cyc);
    end
    n_checks++;
    if (o_trap !== 0) begin
      n_errors++; $display("FAIL mret_no_trap: got %0d want 0", o_trap);
    end
  endtask

  task automatic test_mret_ignored();
    idle_inputs();
    mip = 32'h800; mie = 32'h800; pipe_empty = 1'b0; mtvec = 32'h400; next_pc = 32'h44;
    @(negedge clk);
    pipe_empty = 1'b1; mret_req = 1'b1; mepc = 32'h5000;
    observe(5);
    n_checks++;
    if (o_mret !== 0 || o_trap !== 1 || o_rpc !== 32'h400) begin
      n_errors++; $display("FAIL mret_ignored: mret %0d trap %0d pc %h want 0 1 00000400",
        o_mret, o_trap, o_rpc);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    mip = 32'h880; mie = 32'h880; redirect_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin
        n_errors++; $display("FAIL hold_stable: valid %b pc %h want 1 00000100", redirect_valid, redirect_pc);
      end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fetch_hold, trap_wr, mret_restore, redirect_valid, busy} !== 5'b0 ||
        {mepc_out, mcause_out, redirect_pc} !== 96'd0) begin
      n_errors++; $display("FAIL mid_reset_outputs: flags %b pc %h want 0",
        {fetch_hold, trap_wr, mret_restore, redirect_valid, busy}, redirect_pc);
    end
    mip = 32'd0; redirect_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    observe(4);
    n_checks++;
    if (o_trap !== 0 || o_mret !== 0 || o_redir !== 0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL after_reset_quiet: trap %0d mret %0d redir %0d busy %b want 0",
        o_trap, o_mret, o_redir, busy);
    end
  endtask

  task automatic test_random(input int n);
    logic        elig, do_mret;
    int          code;
    logic [31:0] p, exp_pc;
    for (int t = 0; t < n; t++) begin
      idle_inputs();
      mip = $urandom; mie = $urandom;
      mstatus_mie = ($urandom_range(3) != 0);
      mtvec = $urandom; mepc = $urandom; next_pc = $urandom;
      if ($urandom_range(1) == 0) mtvec = (mtvec & 32'hFFFF_FFFC) | 32'd1;
      do_mret = ($urandom_range(3) == 0);
      mret_req = do_mret;
      p = mip & mie & 32'h888;
      elig = mstatus_mie && (p != 32'd0);
      code = model_code(p);
      observe(6);
      if (do_mret) begin
        n_checks++;
        if (o_mret !== 1 || o_trap !== 0 || o_redir_cyc !== 2 || o_rpc !== (mepc & 32'hFFFF_FFFC)) begin
          n_errors++; $display("FAIL rand_mret[%0d]: mret %0d trap %0d cyc %0d pc %h want 1 0 2 %h",
            t, o_mret, o_trap, o_redir_cyc, o_rpc, mepc & 32'hFFFF_FFFC);
        end
      end else if (elig) begin
        exp_pc = model_vec(mtvec, code);
        n_checks++;
        if (o_trap !== 1 || o_trap_cyc !== 2 || o_mcause !== (32'h8000_0000 | 32'(code)) ||
            o_mepc !== next_pc) begin
          n_errors++; $display("FAIL rand_trap[%0d]: cnt %0d cyc %0d cause %h epc %h want 1 2 %h %h",
            t, o_trap, o_trap_cyc, o_mcause, o_mepc, 32'h8000_0000 | 32'(code), next_pc);
        end
        n_checks++;
        if (o_redir_cyc !== 3 || o_rpc !== exp_pc || o_mret !== 0) begin
          n_errors++; $display("FAIL rand_redir[%0d]: cyc %0d pc %h want 3 %h", t, o_redir_cyc, o_rpc, exp_pc);
        end
      end else begin
        n_checks++;
        if (o_trap !== 0 || o_redir !== 0 || o_mret !== 0) begin
          n_errors++; $display("FAIL rand_quiet[%0d]: trap %0d redir %0d want 0 0", t, o_trap, o_redir);
        end
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_errors++; $display("FAIL rand_idle[%0d]: busy got %b want 0", t, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_trap("mei_direct", 32'h880, 32'h100, 32'h8000_000B, 32'h100);
    test_trap("mei_vectored", 32'h880, 32'h101, 32'h8000_000B, 32'h12C);
    test_trap("msi", 32'h088, 32'h100, 32'h8000_0003, 32'h100);
    test_trap("mti_vectored", 32'h080, 32'h201, 32'h8000_0007, 32'h21C);
    test_trap("wrap", 32'h800, 32'hFFFF_FFFD, 32'h8000_000B, 32'h28);
    test_abort();
    test_abort_vs_empty();
    test_mret_priority();
    test_mret_ignored();
    test_reset_mid();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
